// File: rtl/mb_io_arb_if.sv
// Bus bundle between the two register masters, the arbiter and the shared
// per-channel DMA register port.
interface mb_io_arb_if #(
    parameter int C_ADDR_WIDTH = 12
);
    logic                    m0_stb;
    logic                    m0_we;
    logic [C_ADDR_WIDTH-1:0] m0_addr;
    logic [31:0]             m0_wdata;
    logic                    m0_ready;
    logic [31:0]             m0_rdata;

    logic                    m1_stb;
    logic                    m1_we;
    logic [C_ADDR_WIDTH-1:0] m1_addr;
    logic [31:0]             m1_wdata;
    logic                    m1_ready;
    logic [31:0]             m1_rdata;

    logic [C_ADDR_WIDTH-1:0] reg_addr;
    logic [31:0]             reg_wdata;
    logic                    reg_write;
    logic                    reg_read;
    logic [31:0]             reg_rdata;

    logic                    busy;
    logic                    proto_err;

    // Arbiter side
    modport slave (
        input  m0_stb, m0_we, m0_addr, m0_wdata,
        output m0_ready, m0_rdata,
        input  m1_stb, m1_we, m1_addr, m1_wdata,
        output m1_ready, m1_rdata,
        output reg_addr, reg_wdata, reg_write, reg_read,
        input  reg_rdata,
        output busy, proto_err
    );

    // Environment side: both masters plus the register file
    modport master (
        output m0_stb, m0_we, m0_addr, m0_wdata,
        input  m0_ready, m0_rdata,
        output m1_stb, m1_we, m1_addr, m1_wdata,
        input  m1_ready, m1_rdata,
        input  reg_addr, reg_wdata, reg_write, reg_read,
        output reg_rdata,
        input  busy, proto_err
    );
endinterface

// File: rtl/mb_io_arb.sv
// Round-robin arbiter serialising single-beat MCS IO and host register
// requests onto the shared DMA register port, one transaction in flight.
module mb_io_arb #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_RD_LATENCY = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    mb_io_arb_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] RD_LAT = 4'(C_RD_LATENCY);

    state_t                  state_r;
    logic                    pend0_r, pend1_r;
    logic                    slot0_we_r, slot1_we_r;
    logic [C_ADDR_WIDTH-1:0] slot0_addr_r, slot1_addr_r;
    logic [31:0]             slot0_wdata_r, slot1_wdata_r;
    logic                    cur_r, cur_we_r, last_grant_r;
    logic [3:0]              cnt_r;
    logic [C_ADDR_WIDTH-1:0] reg_addr_r;
    logic [31:0]             reg_wdata_r;
    logic                    reg_write_r, reg_read_r;
    logic                    m0_ready_r, m1_ready_r;
    logic [31:0]             m0_rdata_r, m1_rdata_r;
    logic                    busy_r, proto_err_r;

    logic                    grant_s, sel_s;
    logic                    inflight_s, accept0_s, accept1_s, err_s;
    logic                    sel_we_s;
    logic [C_ADDR_WIDTH-1:0] sel_addr_s;
    logic [31:0]             sel_wdata_s;

    // The RESP cycle is not "in flight": a strobe alongside ready is a new request
    assign inflight_s  = (state_r == ST_ACCESS) || (state_r == ST_WAIT);
    assign accept0_s   = bus.m0_stb && !pend0_r && !(inflight_s && !cur_r);
    assign accept1_s   = bus.m1_stb && !pend1_r && !(inflight_s && cur_r);
    assign err_s       = (bus.m0_stb && !accept0_s) || (bus.m1_stb && !accept1_s);
    assign sel_we_s    = sel_s ? slot1_we_r    : slot0_we_r;
    assign sel_addr_s  = sel_s ? slot1_addr_r  : slot0_addr_r;
    assign sel_wdata_s = sel_s ? slot1_wdata_r : slot0_wdata_r;

    // Grant selection in IDLE: sole requester wins, contention goes to !last_grant
    always_comb begin
        grant_s = 1'b0;
        sel_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            if (pend0_r && pend1_r) begin
                grant_s = 1'b1;
                sel_s   = ~last_grant_r;
            end else if (pend0_r) begin
                grant_s = 1'b1;
                sel_s   = 1'b0;
            end else if (pend1_r) begin
                grant_s = 1'b1;
                sel_s   = 1'b1;
            end else begin
                grant_s = 1'b0;
                sel_s   = 1'b0;
            end
        end else begin
            grant_s = 1'b0;
            sel_s   = 1'b0;
        end
    end

    // Request slots: latch command fields of accepted strobes
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            slot0_we_r    <= 1'b0;
            slot0_addr_r  <= '0;
            slot0_wdata_r <= 32'h0000_0000;
            slot1_we_r    <= 1'b0;
            slot1_addr_r  <= '0;
            slot1_wdata_r <= 32'h0000_0000;
        end else begin
            if (accept0_s) begin
                slot0_we_r    <= bus.m0_we;
                slot0_addr_r  <= bus.m0_addr;
                slot0_wdata_r <= bus.m0_wdata;
            end
            if (accept1_s) begin
                slot1_we_r    <= bus.m1_we;
                slot1_addr_r  <= bus.m1_addr;
                slot1_wdata_r <= bus.m1_wdata;
            end
        end
    end

    // Transaction sequencer with registered register-port and master outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r      <= ST_IDLE;
            pend0_r      <= 1'b0;
            pend1_r      <= 1'b0;
            cur_r        <= 1'b0;
            cur_we_r     <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= 4'd0;
            reg_addr_r   <= '0;
            reg_wdata_r  <= 32'h0000_0000;
            reg_write_r  <= 1'b0;
            reg_read_r   <= 1'b0;
            m0_ready_r   <= 1'b0;
            m1_ready_r   <= 1'b0;
            m0_rdata_r   <= 32'h0000_0000;
            m1_rdata_r   <= 32'h0000_0000;
            busy_r       <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            reg_write_r <= 1'b0;
            reg_read_r  <= 1'b0;
            m0_ready_r  <= 1'b0;
            m1_ready_r  <= 1'b0;
            if (err_s) begin
                proto_err_r <= 1'b1;
            end
            // accept needs pend clear while grant needs pend set, so these never collide
            if (accept0_s) begin
                pend0_r <= 1'b1;
            end else if (grant_s && !sel_s) begin
                pend0_r <= 1'b0;
            end
            if (accept1_s) begin
                pend1_r <= 1'b1;
            end else if (grant_s && sel_s) begin
                pend1_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        cur_r        <= sel_s;
                        cur_we_r     <= sel_we_s;
                        last_grant_r <= sel_s;
                        reg_addr_r   <= sel_addr_s;
                        reg_wdata_r  <= sel_wdata_s;
                        reg_write_r  <= sel_we_s;
                        reg_read_r   <= ~sel_we_s;
                        cnt_r        <= sel_we_s ? 4'd0 : RD_LAT;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cur_we_r) begin
                        state_r <= ST_RESP;
                        if (cur_r) begin
                            m1_ready_r <= 1'b1;
                            m1_rdata_r <= 32'h0000_0000;
                        end else begin
                            m0_ready_r <= 1'b1;
                            m0_rdata_r <= 32'h0000_0000;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // cnt reaches 1 in the cycle reg_rdata becomes valid
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_RESP;
                        if (cur_r) begin
                            m1_ready_r <= 1'b1;
                            m1_rdata_r <= bus.reg_rdata;
                        end else begin
                            m0_ready_r <= 1'b1;
                            m0_rdata_r <= bus.reg_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reg_addr  = reg_addr_r;
    assign bus.reg_wdata = reg_wdata_r;
    assign bus.reg_write = reg_write_r;
    assign bus.reg_read  = reg_read_r;
    assign bus.m0_ready  = m0_ready_r;
    assign bus.m0_rdata  = m0_rdata_r;
    assign bus.m1_ready  = m1_ready_r;
    assign bus.m1_rdata  = m1_rdata_r;
    assign bus.busy      = busy_r;
    assign bus.proto_err = proto_err_r;
endmodule

// File: tb/tb_mb_io_arb.sv
// Bench for mb_io_arb: directed scenarios plus random traffic, every cycle
// compared against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_mb_io_arb;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mb_io_arb_if #(.C_ADDR_WIDTH(AW)) bus ();
    mb_io_arb #(.C_ADDR_WIDTH(AW), .C_RD_LATENCY(LAT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: pending slots plus the timing window of the active transaction
    bit            m_pend [2];
    bit            m_we   [2];
    logic [AW-1:0] m_addr [2];
    logic [31:0]   m_wd   [2];
    bit            m_act, m_act_we, m_perr;
    int            m_act_m, m_g, m_r, m_last;
    logic [AW-1:0] m_act_addr, m_raddr;
    logic [31:0]   m_rwd;
    logic [31:0]   m_rdata [2];

    // Register file read value as a function of address
    function automatic logic [31:0] rd_fn(input logic [AW-1:0] a);
        if (a == 12'h810) return 32'h0000_8001;
        return {a, 8'h5A, a};
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_wd[i] = 32'h0; m_rdata[i] = 32'h0;
        end
        m_act = 1'b0; m_act_we = 1'b0; m_perr = 1'b0; m_act_m = 0;
        m_g = -10; m_r = -10; m_last = 1;
        m_act_addr = '0; m_raddr = '0; m_rwd = 32'h0;
    endtask

    task automatic model_edge();
        bit            stb [2];
        bit            we  [2];
        logic [AW-1:0] ad  [2];
        logic [31:0]   wd  [2];
        bit            pre [2];
        bit            inf [2];
        int            m;
        if (sys_rst) begin
            reset_model();
            return;
        end
        stb[0] = bus.m0_stb; we[0] = bus.m0_we; ad[0] = bus.m0_addr; wd[0] = bus.m0_wdata;
        stb[1] = bus.m1_stb; we[1] = bus.m1_we; ad[1] = bus.m1_addr; wd[1] = bus.m1_wdata;
        for (int i = 0; i < 2; i++) begin
            pre[i] = m_pend[i];
            inf[i] = m_act && (m_act_m == i) && (cyc < m_r);
        end
        if (!m_act && (pre[0] || pre[1])) begin
            m = (pre[0] && pre[1]) ? (1 - m_last) : (pre[0] ? 0 : 1);
            m_act = 1'b1; m_act_m = m; m_act_we = m_we[m]; m_act_addr = m_addr[m];
            m_raddr = m_addr[m]; m_rwd = m_wd[m];
            m_g = cyc; m_r = cyc + 2 + (m_we[m] ? 0 : LAT);
            m_last = m; m_pend[m] = 1'b0;
        end else if (m_act && cyc == m_r) begin
            m_act = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (stb[i]) begin
                if (!pre[i] && !inf[i]) begin
                    m_pend[i] = 1'b1; m_we[i] = we[i]; m_addr[i] = ad[i]; m_wd[i] = wd[i];
                end else begin
                    m_perr = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit strobe, rdy0, rdy1;
        strobe = m_act && (m_g == cyc - 1);
        rdy0 = m_act && (cyc == m_r) && (m_act_m == 0);
        rdy1 = m_act && (cyc == m_r) && (m_act_m == 1);
        if (rdy0) m_rdata[0] = m_act_we ? 32'h0 : rd_fn(m_act_addr);
        if (rdy1) m_rdata[1] = m_act_we ? 32'h0 : rd_fn(m_act_addr);
        check_val("reg_write", 32'(bus.reg_write), 32'(strobe && m_act_we));
        check_val("reg_read",  32'(bus.reg_read),  32'(strobe && !m_act_we));
        check_val("reg_addr",  32'(bus.reg_addr),  32'(m_raddr));
        check_val("reg_wdata", bus.reg_wdata, m_rwd);
        check_val("m0_ready",  32'(bus.m0_ready),  32'(rdy0));
        check_val("m1_ready",  32'(bus.m1_ready),  32'(rdy1));
        check_val("m0_rdata",  bus.m0_rdata, m_rdata[0]);
        check_val("m1_rdata",  bus.m1_rdata, m_rdata[1]);
        check_val("busy",      32'(bus.busy),      32'(m_act));
        check_val("proto_err", 32'(bus.proto_err), 32'(m_perr));
    endtask

    // Observed events, used by the directed timing checks
    int            ev_wr = -1, ev_rd = -1, ev_rdy0 = -1, ev_rdy1 = -1;
    int            n_reads = 0, n_rdy = 0, rd_due = -1;
    logic [AW-1:0] rd_addr = '0, last_rd_addr = '0;
    int            order [$];

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
        if (bus.reg_write) ev_wr = cyc;
        if (bus.reg_read) begin
            ev_rd = cyc; n_reads++; rd_due = cyc + LAT;
            rd_addr = bus.reg_addr; last_rd_addr = bus.reg_addr;
        end
        if (bus.m0_ready) begin ev_rdy0 = cyc; n_rdy++; order.push_back(0); end
        if (bus.m1_ready) begin ev_rdy1 = cyc; n_rdy++; order.push_back(1); end
        bus.reg_rdata = (cyc == rd_due) ? rd_fn(rd_addr) : $urandom;
        sys_rst = 1'b0;
        bus.m0_stb = 1'b0; bus.m0_we = 1'($urandom); bus.m0_addr = AW'($urandom); bus.m0_wdata = $urandom;
        bus.m1_stb = 1'b0; bus.m1_we = 1'($urandom); bus.m1_addr = AW'($urandom); bus.m1_wdata = $urandom;
    endtask

    task automatic req(input int m, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
        if (m == 0) begin
            bus.m0_stb = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_stb = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            sys_rst = 1'b1;
            step();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int t0, rdy_before, rd_before, k;
        bit out0, out1;
        reset_model();
        sys_rst = 1'b1;
        bus.m0_stb = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = 32'h0;
        bus.m1_stb = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = 32'h0;
        bus.reg_rdata = 32'h0;
        do_reset();
        idle(2);

        // Master 0 write
        t0 = cyc;
        req(0, 1'b1, 12'h104, 32'hDEAD_BEEF);
        idle(6);
        check_val("t1_wr_cycle",  32'(ev_wr - t0),   32'd2);
        check_val("t1_rdy_cycle", 32'(ev_rdy0 - t0), 32'd3);

        // Master 1 read
        t0 = cyc;
        req(1, 1'b0, 12'h810, 32'h0);
        idle(3 + LAT + 3);
        check_val("t2_rd_cycle",  32'(ev_rd - t0),   32'd2);
        check_val("t2_rdy_cycle", 32'(ev_rdy1 - t0), 32'(3 + LAT));
        check_val("t2_rdata",     bus.m1_rdata,      32'h0000_8001);

        // Contention after reset: alternation 0,1,0,1,...
        do_reset();
        order.delete();
        for (int rnd = 0; rnd < 4; rnd++) begin
            t0 = cyc;
            req(0, 1'b1, 12'(rnd), $urandom);
            req(1, 1'b1, 12'(rnd + 16), $urandom);
            step();
            k = 0;
            while (order.size() < 2 * (rnd + 1) && k < 40) begin
                step();
                k++;
            end
            check_val("t3_no_timeout", 32'(k < 40), 32'd1);
            if (rnd == 0) check_val("t3_back_to_back", 32'(ev_rdy1 - ev_rdy0), 32'd3);
        end
        check_val("t3_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size() && i < 8; i++) check_val("t3_order", 32'(order[i]), 32'(i % 2));

        // Protocol error: second m0 strobe while the first is pending
        do_reset();
        rd_before = n_reads;
        req(0, 1'b0, 12'h100, 32'h0);
        step();
        req(0, 1'b0, 12'h200, 32'h0);
        idle(10);
        check_val("t4_reads",    32'(n_reads - rd_before), 32'd1);
        check_val("t4_rd_addr",  32'(last_rd_addr),        32'h100);
        check_val("t4_perr",     32'(bus.proto_err),       32'd1);
        idle(5);
        check_val("t4_perr_sticky", 32'(bus.proto_err), 32'd1);
        do_reset();
        check_val("t4_perr_clear", 32'(bus.proto_err), 32'd0);

        // Reset in WAIT with m1 pending
        idle(2);
        req(0, 1'b0, 12'h0AB, 32'h0);
        step();
        req(1, 1'b0, 12'h810, 32'h0);
        step();
        step();
        rdy_before = n_rdy;
        sys_rst = 1'b1;
        step();
        check_val("t5_busy_after_rst", 32'(bus.busy), 32'd0);
        idle(8);
        check_val("t5_no_ready", 32'(n_rdy - rdy_before), 32'd0);
        t0 = cyc;
        req(1, 1'b0, 12'h810, 32'h0);
        idle(3 + LAT + 2);
        check_val("t5_rdy_cycle", 32'(ev_rdy1 - t0), 32'(3 + LAT));
        check_val("t5_rdata",     bus.m1_rdata,      32'h0000_8001);

        // Random traffic, mostly legal, occasional illegal strobes and resets
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                out0 = m_pend[0] || (m_act && m_act_m == 0 && cyc < m_r);
                out1 = m_pend[1] || (m_act && m_act_m == 1 && cyc < m_r);
                if (!out0 ? ($urandom % 3 == 0) : ($urandom % 50 == 0))
                    req(0, 1'($urandom), AW'($urandom), $urandom);
                if (!out1 ? ($urandom % 3 == 0) : ($urandom % 50 == 0))
                    req(1, 1'($urandom), AW'($urandom), $urandom);
                if ($urandom % 300 == 0) sys_rst = 1'b1;
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mb_io_arb.md
Name: mb_io_arb

Overview:
- Two-master arbiter for the per-channel DMA register port (0x000–0x3FF, plus ctrl bank).
- Master 0 is the MicroBlaze MCS IO bus, after strobe decode. Master 1 is the host-side register access path.
- Serialises their single-beat read/write requests onto one shared register port, round-robin, one transaction in flight.
- Returns a ready pulse and read data to the requesting master.

Parameters:
- C_ADDR_WIDTH, 12, register address width on all ports.
- C_RD_LATENCY, 2, cycles from reg_read strobe to valid reg_rdata. Legal range 1..15.

Ports:
- sys_clk  in  1  clock, all logic rising-edge
- sys_rst  in  1  synchronous active-high reset
- m0_stb  in  1  master 0 request strobe, 1-cycle pulse
- m0_we  in  1  master 0 write (1) / read (0), qualified by m0_stb
- m0_addr  in  C_ADDR_WIDTH  master 0 address, qualified by m0_stb
- m0_wdata  in  32  master 0 write data, qualified by m0_stb
- m0_ready  out  1  master 0 completion pulse
- m0_rdata  out  32  master 0 read data, valid with m0_ready
- m1_stb, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata  same as m0_*, for master 1
- reg_addr  out  C_ADDR_WIDTH  shared port address
- reg_wdata  out  32  shared port write data
- reg_write  out  1  shared port write strobe, 1 cycle
- reg_read  out  1  shared port read strobe, 1 cycle
- reg_rdata  in  32  shared port read data
- busy  out  1  transaction in flight (state != IDLE)
- proto_err  out  1  sticky: strobe received while that master already had a request outstanding

Behaviour:
- Reset values:
  - all outputs 0; both pending slots clear; state IDLE
  - round-robin pointer last_grant=1, so master 0 wins first
  - latency counter 0; proto_err 0
- Request capture:
  - mN_stb sampled at the clock edge latches we/addr/wdata into slot N and sets pendN.
  - mN_stb while pendN=1 or master N is in flight: request ignored, slot unchanged, proto_err set. proto_err clears only on reset.
  - mN_stb in the same cycle as mN_ready is legal and is captured as a new request.
- States:
  - IDLE: if any pend, select a master.
    - Only one pending: select it.
    - Both pending: select !last_grant.
    - On the edge: register reg_addr/reg_wdata from the selected slot, assert reg_write or reg_read for exactly one cycle, clear its pend, set last_grant, load cnt=C_RD_LATENCY for reads.
    - Go to ACCESS.
  - ACCESS (strobe cycle):
    - Write: go to RESP.
    - Read: go to WAIT.
  - WAIT: cnt decrements each cycle. When reg_rdata is valid (C_RD_LATENCY cycles after the strobe cycle), capture it into mN_rdata and go to RESP.
  - RESP: mN_ready=1 for exactly one cycle; mN_rdata holds the captured data (0 for writes); return to IDLE.
    - A request already pending is arbitrated in that same IDLE cycle; no extra bubble beyond RESP→IDLE.
- Latency, stb sampled at cycle 0, bus idle:
  - reg strobe visible in cycle 2
  - write: ready in cycle 3
  - read: ready in cycle 3+C_RD_LATENCY
- Output holds:
  - reg_addr and reg_wdata hold their values until the next grant.
  - mN_rdata holds until the next mN_ready.
- Fairness: after serving master N, the other master wins the next contention. There is no starvation while both keep requesting.
- Reset mid-transaction: the transaction is abandoned, no ready is issued, and pending requests are discarded. Masters must re-issue.
- reg_write and reg_read are never high in the same cycle. They are never high in two consecutive cycles.

Test Plan:
- Master 0 write:
  - m0 write addr 0x104 data 0xDEADBEEF at cycle 0, m1 idle.
  - Required: reg_write=1 with reg_addr=0x104, reg_wdata=0xDEADBEEF in cycle 2; m0_ready in cycle 3; m0_rdata=0.
- Master 1 read, C_RD_LATENCY=2:
  - m1 read 0x810; model drives reg_rdata=0x00008001 two cycles after reg_read.
  - Required: m1_ready in cycle 5 with m1_rdata=0x00008001; busy high cycles 2–5.
- Simultaneous requests after reset:
  - m0 and m1 both strobe in cycle 0.
  - Required: m0 served first, then m1 in the IDLE cycle after m0's RESP.
  - Repeating the contention 4 times gives order 0,1,0,1,0,1,0,1.
- Protocol error:
  - m0 read strobe, then a second m0 strobe 1 cycle later with addr 0x200.
  - Required: the second request is ignored, only one reg_read issued (original addr), proto_err=1 and stays 1 until sys_rst.
- Reset mid-read:
  - Assert sys_rst during WAIT with m1 also pending.
  - Required: no m0_ready/m1_ready, all outputs 0 next cycle.
  - A fresh m1 request after reset completes normally with standard latency.
